ff_frame_loader: RTL and testbench
==================================

// Module: ff_frame_loader
// PURPOSE
//  Upstream feeder for feed_forward. Collects a byte stream from the UART receiver and packs it into 32-bit words.
//  Buffers one complete network frame (weights, bias block, neuron inputs, end marker) in an internal word RAM.
//  Once the whole frame is held, bursts it gap-free into feed_forward's load port, pulses start with the layer sizes,
//  then waits for feed_forward's done level (oldu). The burst must not stall, so the full frame is buffered first.
// PARAMETERS
//  DEPTH    256  frame buffer size in words; equals feed_forward SRAM depth (8-bit address)
//  AW       8    buffer address width, log2(DEPTH)
//  TIMEOUT  2**20  cycles allowed in WAIT_DONE before err_code=3
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  rx_valid     in   1   one-cycle strobe: rx_byte is valid
//  rx_byte      in   8   received byte; words arrive MSB first
//  layer_cfg    in   12  {L1,L2,L3,L4} layer sizes, 3 bits each; sampled on the first byte of a frame
//  ff_done      in   1   feed_forward oldu (level)
//  ff_load      out  1   one-cycle pulse: opens the feed_forward load window
//  ff_data      out  32  word streamed into feed_forward
//  ff_start     out  1   one-cycle pulse: starts inference
//  ff_layers    out  12  held copy of layer_cfg; drives first_layer..fourth_layer
//  busy         out  1   high in every state except IDLE
//  frame_done   out  1   one-cycle pulse when ff_done is seen
//  err_code     out  2   0 ok, 1 overflow, 2 format/checksum, 3 timeout; held until the next frame's first byte
// BEHAVIOUR
//  Reset: every output 0 and the FSM in IDLE. Buffer contents are don't-care.
//   Reset mid-frame or mid-burst aborts immediately and cleanly.
//  FSM states: IDLE -> COLLECT -> (CHECK) -> BURST -> START -> WAIT_DONE -> IDLE.
//  IDLE: on the first rx_valid, sample layer_cfg into ff_layers, clear err_code, clear the counters, then go to COLLECT.
//  COLLECT:
//   - A 2-bit byte counter shifts bytes into a word. On the 4th byte the word is written to buf[wcnt] and wcnt increments.
//   - Track markers: 32'h80000000 (bias block), 32'hFFFFFFFF (neuron block). Sum all words mod 2^32.
//   - Word 32'hFFFFFFF0 (END) is stored, and the FSM goes to BURST (or CHECK when checksum is enabled).
//   - At END, the bias marker count and neuron marker count must each be exactly 1, and bias must precede neuron.
//     Otherwise err_code=2 and go to IDLE.
//   - A word arriving when wcnt==DEPTH-1 that is not END: err_code=1, frame discarded, go to IDLE.
//  BURST: N = wcnt words.
//   - Cycle 0: ff_load=1, ff_data=0.
//   - Cycles 1..N: ff_data=buf[i], with exactly one word per cycle and no bubbles.
//   - The last word driven is END. After it, ff_data returns to 0.
//   - Buffer read latency is 1 cycle, so the read of buf[0] is issued in cycle 0.
//  START: one idle cycle, then ff_start=1 for one cycle. ff_layers stay stable from the IDLE sample until return to IDLE.
//  WAIT_DONE: a cycle counter runs.
//   - ff_done=1: frame_done pulses, go to IDLE.
//   - Counter reaches TIMEOUT: err_code=3, go to IDLE.
//  rx_valid outside IDLE/COLLECT: the byte is dropped silently. busy=1 tells the sender to hold off.
//  Simultaneous events: rx_valid and ff_done in the same WAIT_DONE cycle -> the byte is dropped.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - After END, COLLECT expects one extra 4-byte word: the mod-2^32 sum of all frame words including END.
//   - The checksum word is not stored and not burst. CHECK compares it against the running sum.
//   - Mismatch -> err_code=2, go to IDLE. Match -> BURST.
//   - An overflow while waiting for the checksum is still err_code=1.
//  Not defined: END goes straight to BURST, and no extra word is expected.
// TESTING
//  1. Frame {W0,W1,80000000,B0,FFFFFFFF,X0,X1,FFFFFFF0} as 32 bytes, cfg L=2,1,1,1.
//     -> ff_load pulse, then 8 consecutive ff_data words matching the frame, 1 idle cycle,
//        ff_start pulse, ff_layers=12'o2111.
//  2. Same frame, then hold ff_done=1 50 cycles after start -> frame_done pulses once, busy drops the next cycle.
//  3. 256 words with no END -> err_code=1 on the 256th word; no ff_load ever asserted.
//  4. Frame missing the 80000000 marker -> err_code=2 at END; ff_load stays 0.
//  5. Assert rst low midway through the BURST of test 1 -> ff_load, ff_data, ff_start and busy are all 0 immediately.
//     A fresh frame afterwards bursts correctly.
//  6. With LOADER_CHECKSUM_EN, test 1 with a correct sum -> identical burst. Sum+1 -> err_code=2 and no burst.

Source files
------------

// File: rtl/ff_frame_loader.sv
// ff_frame_loader: packs UART bytes into 32-bit words, buffers one complete network frame, then bursts it into feed_forward.
// Build option LOADER_CHECKSUM_EN: a trailing mod-2^32 frame checksum word is verified before the burst.
module ff_frame_loader #(
   parameter int DEPTH   = 256,
   parameter int AW      = 8,
   parameter int TIMEOUT = 2**20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   input  logic [11:0] layer_cfg,
   input  logic        ff_done,
   output logic        ff_load,
   output logic [31:0] ff_data,
   output logic        ff_start,
   output logic [11:0] ff_layers,
   output logic        busy,
   output logic        frame_done,
   output logic [1:0]  err_code
);

   localparam int          TW        = $clog2(TIMEOUT + 1);
   localparam logic [31:0] BIAS_MARK = 32'h8000_0000;
   localparam logic [31:0] NEUR_MARK = 32'hFFFF_FFFF;
   localparam logic [31:0] END_MARK  = 32'hFFFF_FFF0;
   localparam logic [AW:0] LAST_W    = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE_W     = (AW+1)'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_CHECK   = 3'd2,
      S_BURST   = 3'd3,
      S_START   = 3'd4,
      S_WAIT    = 3'd5
   } state_t;

   state_t        state_r;
   logic [1:0]    byte_cnt_r;
   logic [23:0]   shift_r;
   logic [AW:0]   wcnt_r;
   logic [AW:0]   rd_idx_r;
   logic [1:0]    bias_cnt_r;
   logic [1:0]    neur_cnt_r;
   logic          order_err_r;
   logic [TW-1:0] tmo_cnt_r;
   logic          ff_load_r;
   logic [31:0]   ff_data_r;
   logic          ff_start_r;
   logic [11:0]   ff_layers_r;
   logic          busy_r;
   logic          frame_done_r;
   logic [1:0]    err_r;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   sum_r;
`endif

   logic [31:0]   mem_r [DEPTH];
   logic [31:0]   word_s;
   logic          word_full_s;
   logic          wr_en_s;

   // A frame is well formed when exactly one bias marker precedes exactly one neuron marker.
   function automatic logic frame_format_ok(input logic [1:0] bias_n,
                                            input logic [1:0] neur_n,
                                            input logic       order_bad);
      return (bias_n == 2'd1) && (neur_n == 2'd1) && !order_bad;
   endfunction

   // Byte assembly into a word and buffer write strobe; the overflowing word is never written.
   always_comb begin
      word_s      = {shift_r, rx_byte};
      word_full_s = 1'b0;
      wr_en_s     = 1'b0;
      if ((state_r == S_COLLECT) && rx_valid && (byte_cnt_r == 2'd3)) begin
         word_full_s = 1'b1;
         wr_en_s     = (word_s == END_MARK) || (wcnt_r != LAST_W);
      end else begin
         word_full_s = 1'b0;
         wr_en_s     = 1'b0;
      end
   end

   // Frame buffer write port; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wcnt_r[AW-1:0]] <= word_s;
      end
   end

   // Loader FSM with registered outputs; ff_data_r doubles as the buffer read register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= S_IDLE;
         byte_cnt_r   <= 2'd0;
         shift_r      <= 24'h0;
         wcnt_r       <= '0;
         rd_idx_r     <= '0;
         bias_cnt_r   <= 2'd0;
         neur_cnt_r   <= 2'd0;
         order_err_r  <= 1'b0;
         tmo_cnt_r    <= '0;
         ff_load_r    <= 1'b0;
         ff_data_r    <= 32'h0;
         ff_start_r   <= 1'b0;
         ff_layers_r  <= 12'h0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         err_r        <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
         sum_r        <= 32'h0;
`endif
      end else begin
         ff_load_r    <= 1'b0;
         ff_start_r   <= 1'b0;
         frame_done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               ff_data_r <= 32'h0;
               if (rx_valid) begin
                  ff_layers_r <= layer_cfg;
                  err_r       <= 2'd0;
                  shift_r     <= {16'h0, rx_byte};
                  byte_cnt_r  <= 2'd1;
                  wcnt_r      <= '0;
                  bias_cnt_r  <= 2'd0;
                  neur_cnt_r  <= 2'd0;
                  order_err_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  sum_r       <= 32'h0;
`endif
                  busy_r      <= 1'b1;
                  state_r     <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (rx_valid) begin
                  shift_r    <= word_s[23:0];
                  byte_cnt_r <= byte_cnt_r + 2'd1;
               end
               if (word_full_s) begin
                  if (word_s == END_MARK) begin
                     wcnt_r <= wcnt_r + ONE_W;
`ifdef LOADER_CHECKSUM_EN
                     sum_r  <= sum_r + word_s;
`endif
                     if (frame_format_ok(bias_cnt_r, neur_cnt_r, order_err_r)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_r   <= S_CHECK;
`else
                        ff_load_r <= 1'b1;
                        rd_idx_r  <= '0;
                        state_r   <= S_BURST;
`endif
                     end else begin
                        err_r   <= 2'd2;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                     end
                  end else if (wcnt_r == LAST_W) begin
                     err_r   <= 2'd1;
                     busy_r  <= 1'b0;
                     state_r <= S_IDLE;
                  end else begin
                     wcnt_r <= wcnt_r + ONE_W;
`ifdef LOADER_CHECKSUM_EN
                     sum_r  <= sum_r + word_s;
`endif
                     if ((word_s == BIAS_MARK) && (bias_cnt_r != 2'd3)) begin
                        bias_cnt_r <= bias_cnt_r + 2'd1;
                     end
                     if (word_s == NEUR_MARK) begin
                        if (neur_cnt_r != 2'd3) begin
                           neur_cnt_r <= neur_cnt_r + 2'd1;
                        end
                        if (bias_cnt_r == 2'd0) begin
                           order_err_r <= 1'b1;
                        end
                     end
                  end
               end
            end
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
               if (rx_valid) begin
                  shift_r    <= word_s[23:0];
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     if (word_s == sum_r) begin
                        ff_load_r <= 1'b1;
                        rd_idx_r  <= '0;
                        state_r   <= S_BURST;
                     end else begin
                        err_r   <= 2'd2;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                     end
                  end
               end
`else
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
`endif
            end
            S_BURST: begin
               if (rd_idx_r < wcnt_r) begin
                  ff_data_r <= mem_r[rd_idx_r[AW-1:0]];
                  rd_idx_r  <= rd_idx_r + ONE_W;
               end else begin
                  ff_data_r <= 32'h0;
                  state_r   <= S_START;
               end
            end
            S_START: begin
               ff_start_r <= 1'b1;
               tmo_cnt_r  <= '0;
               state_r    <= S_WAIT;
            end
            S_WAIT: begin
               if (ff_done) begin
                  frame_done_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= S_IDLE;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  err_r   <= 2'd3;
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign ff_load    = ff_load_r;
   assign ff_data    = ff_data_r;
   assign ff_start   = ff_start_r;
   assign ff_layers  = ff_layers_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign err_code   = err_r;

endmodule

// File: tb/tb_ff_frame_loader.sv
// Directed testbench for ff_frame_loader: framing, burst timing, errors, timeout and async reset.
module tb_ff_frame_loader;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [11:0] layer_cfg;
   logic        ff_done;
   logic        ff_load;
   logic [31:0] ff_data;
   logic        ff_start;
   logic [11:0] ff_layers;
   logic        busy;
   logic        frame_done;
   logic [1:0]  err_code;

   int          n_chk = 0;
   int          n_bad = 0;
   int          load_cnt = 0;
   int          lc0;
   logic [11:0] exp_layers;
   logic [31:0] frm [0:255];
   logic [31:0] sum_sent;
   logic        got;

   ff_frame_loader #(.DEPTH(256), .AW(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .layer_cfg(layer_cfg), .ff_done(ff_done), .ff_load(ff_load),
      .ff_data(ff_data), .ff_start(ff_start), .ff_layers(ff_layers),
      .busy(busy), .frame_done(frame_done), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ff_load) load_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
   endtask

   // Sends frm[0..n-1]; layer_cfg is scrambled after the first byte to prove it was sampled once.
   task automatic send_frame(input int n, input bit add_sum, input logic [31:0] adj);
      logic [31:0] s;
      logic [31:0] w;
      s = 32'h0;
      for (int i = 0; i < n; i++) begin
         w = frm[i];
         s = s + w;
         for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8]);
            if (i == 0 && k == 3) begin
               chk("first_byte_busy", busy, 1);
               chk("first_byte_err_clear", err_code, 0);
               layer_cfg = ~layer_cfg;
            end
         end
      end
      if (add_sum) begin
`ifdef LOADER_CHECKSUM_EN
         send_word(s + adj);
`else
         sum_sent = s + adj;
`endif
      end
   endtask

   task automatic check_burst(input int n, input string tag);
      chk({tag, "_load"}, ff_load, 1);
      chk({tag, "_data_c0"}, ff_data, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) chk({tag, "_load_drop"}, ff_load, 0);
         chk({tag, "_data"}, ff_data, frm[i]);
      end
      @(negedge clk);
      chk({tag, "_idle_data"}, ff_data, 0);
      chk({tag, "_idle_start"}, ff_start, 0);
      @(negedge clk);
      chk({tag, "_start"}, ff_start, 1);
      chk({tag, "_layers"}, ff_layers, exp_layers);
   endtask

   task automatic load_frame1();
      frm[0] = 32'h1122_3344; frm[1] = 32'h5566_7788;
      frm[2] = 32'h8000_0000; frm[3] = 32'h0A0B_0C0D;
      frm[4] = 32'hFFFF_FFFF; frm[5] = 32'h0102_0304;
      frm[6] = 32'h0000_0005; frm[7] = 32'hFFFF_FFF0;
   endtask

   initial begin
      rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; layer_cfg = 12'h0; ff_done = 1'b0;
      sum_sent = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {ff_load, ff_start, busy, frame_done, err_code}, 0);
      chk("rst_data", ff_data, 0);
      chk("rst_layers", ff_layers, 0);
      rst = 1'b1;
      @(negedge clk);

      // Test 1: basic frame, L=2,1,1,1
      load_frame1();
      exp_layers = 12'o2111;
      layer_cfg  = exp_layers;
      send_frame(8, 1'b1, 32'h0);
      check_burst(8, "t1");

      // Test 2: ff_done 50 cycles after start
      repeat (50) @(negedge clk);
      chk("t2_wait_busy", busy, 1);
      chk("t2_wait_layers", ff_layers, 12'o2111);
      chk("t2_no_early_done", frame_done, 0);
      ff_done = 1'b1;
      @(negedge clk);
      chk("t2_frame_done", frame_done, 1);
      chk("t2_busy_drop", busy, 0);
      chk("t2_err", err_code, 0);
      @(negedge clk);
      chk("t2_done_once", frame_done, 0);
      ff_done = 1'b0;

      // Test 3: 256 words without END overflow on the 256th
      for (int i = 0; i < 256; i++) frm[i] = 32'h0000_1000 + i;
      lc0 = load_cnt;
      layer_cfg = 12'o1234;
      send_frame(255, 1'b0, 32'h0);
      chk("t3_255_err", err_code, 0);
      chk("t3_255_busy", busy, 1);
      send_word(frm[255]);
      chk("t3_ovf_err", err_code, 1);
      chk("t3_ovf_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("t3_err_held", err_code, 1);
      chk("t3_no_load", load_cnt, lc0);

      // Boundary: END as the 256th word is accepted, then let WAIT_DONE time out
      frm[0] = 32'h8000_0000; frm[1] = 32'hFFFF_FFFF; frm[255] = 32'hFFFF_FFF0;
      exp_layers = 12'o7654;
      layer_cfg  = exp_layers;
      send_frame(256, 1'b1, 32'h0);
      check_burst(256, "full");
      repeat (TMO - 2) @(negedge clk);
      chk("tmo_still_busy", busy, 1);
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         if (!busy) got = 1'b1;
      end
      chk("tmo_idle", got, 1);
      chk("tmo_err", err_code, 3);

      // Test 4: missing bias marker
      frm[0] = 32'h1122_3344; frm[1] = 32'h5566_7788; frm[2] = 32'h0A0B_0C0D;
      frm[3] = 32'hFFFF_FFFF; frm[4] = 32'h0102_0304; frm[5] = 32'hFFFF_FFF0;
      chk("t4_err3_held", err_code, 3);
      lc0 = load_cnt;
      layer_cfg = 12'o1111;
      send_frame(6, 1'b0, 32'h0);
      chk("t4_fmt_err", err_code, 2);
      chk("t4_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("t4_no_load", load_cnt, lc0);

      // Test 5: async reset in the middle of a burst, then a fresh frame
      load_frame1();
      exp_layers = 12'o2111;
      layer_cfg  = exp_layers;
      send_frame(8, 1'b1, 32'h0);
      chk("t5_load", ff_load, 1);
      @(negedge clk);
      @(negedge clk);
      chk("t5_mid_data", ff_data, frm[1]);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_ctrl", {ff_load, ff_start, busy}, 0);
      chk("t5_rst_data", ff_data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      layer_cfg = exp_layers;
      send_frame(8, 1'b1, 32'h0);
      check_burst(8, "t5");

      // rx_valid coinciding with ff_done: the byte must be dropped
      @(negedge clk);
      ff_done  = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = 8'h5A;
      @(negedge clk);
      rx_valid = 1'b0;
      ff_done  = 1'b0;
      chk("t5_sim_done", frame_done, 1);
      chk("t5_sim_busy", busy, 0);
      exp_layers = 12'o3210;
      layer_cfg  = exp_layers;
      send_frame(8, 1'b1, 32'h0);
      check_burst(8, "t5c");
      ff_done = 1'b1;
      @(negedge clk);
      chk("t5c_done", frame_done, 1);
      ff_done = 1'b0;

`ifdef LOADER_CHECKSUM_EN
      // Test 6: checksum off by one
      lc0 = load_cnt;
      layer_cfg = 12'o2111;
      send_frame(8, 1'b1, 32'h1);
      chk("t6_sum_err", err_code, 2);
      chk("t6_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("t6_no_load", load_cnt, lc0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
